// File: rtl/alu_iterative_if.sv
// Request/result bundle between the ID/EX stage and the iterative execute-stage ALU.
// Latency: none; this interface only groups wires.
// Backpressure: busy_o tells the requester to hold off; start_i is ignored while it is high.
//
// Ports (master = requester, slave = ALU):
//   start_i, ALUCtrl_i, data1_i, data2_i : request side, driven by the master
//   data_o, zero_o, done_o, busy_o       : result side, driven by the slave
interface alu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             done_o;
  logic             busy_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, zero_o, done_o, busy_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, zero_o, done_o, busy_o
  );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU: add/sub/and/or in one cycle, mul as a WIDTH-step shift-add loop.
// Latency: 1 edge for add/sub/and/or/unused codes, WIDTH+1 edges for mul; done_o pulses once.
// Backpressure: busy_o is high during mul; start_i is dropped (not queued) while busy.
//
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset, overrides everything including a running mul
//   bus   : slave side of alu_iterative_if (request operands/code, registered result/flags)
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_iterative_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             done_q;

  logic             busy;
  logic             last_step;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] op_res;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start_i && (bus.ALUCtrl_i == OP_MUL)) begin
          state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        if (last_step) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath combinational logic
  always_comb begin
    busy      = (state == ST_MUL);
    last_step = (cnt == CW'(WIDTH - 1));
    // The final iteration's add must be folded into the written result,
    // so the result path takes the post-add value rather than acc itself.
    acc_step  = mplier[0] ? (acc + mcand) : acc;
    case (bus.ALUCtrl_i)
      OP_ADD:  op_res = bus.data1_i + bus.data2_i;
      OP_SUB:  op_res = bus.data1_i - bus.data2_i;
      OP_AND:  op_res = bus.data1_i & bus.data2_i;
      OP_OR:   op_res = bus.data1_i | bus.data2_i;
      default: op_res = '0;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (bus.ALUCtrl_i == OP_MUL) begin
              mcand  <= bus.data1_i;
              mplier <= bus.data2_i;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              data_q <= op_res;
              zero_q <= (op_res == '0);
              done_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            data_q <= acc_step;
            zero_q <= (acc_step == '0);
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_o = data_q;
  assign bus.zero_o = zero_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = busy;

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: directed cases plus random ops, scoreboard-checked.
// Expected results come from a plain-arithmetic reference model; a negedge monitor pops on done_o.
// Also checks result hold between completions, busy duration per mul, and reset values.
module tb_alu_iterative;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_iterative_if #(.WIDTH(W)) bus ();

  alu_iterative #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    int           edge_no;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           edge_cnt = 0;
  logic         rst_at_edge = 1'b1;
  int           busy_run = 0;
  logic [W-1:0] last_data = '0;
  logic         last_zero = 1'b0;

  always @(posedge clk) begin
    edge_cnt    <= edge_cnt + 1;
    rst_at_edge <= rst;
  end

  function automatic logic [W-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (c)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b100: begin
        p = (2*W)'(a) * (2*W)'(b);
        return p[W-1:0];
      end
      default: return '0;
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      checks++;
      if (bus.data_o !== '0 || bus.zero_o !== 1'b0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs data=%h zero=%b done=%b busy=%b required all 0",
                 bus.data_o, bus.zero_o, bus.done_o, bus.busy_o);
      end
      last_data = '0;
      last_zero = 1'b0;
      busy_run  = 0;
    end else begin
      if (bus.busy_o === 1'b1) begin
        busy_run++;
      end else if (busy_run > 0) begin
        checks++;
        if (busy_run != W) begin
          errors++;
          $display("FAIL busy_length got %0d cycles required %0d", busy_run, W);
        end
        busy_run = 0;
      end
      if (sb.size() == 0) begin
        checks++;
        if (bus.busy_o !== 1'b0) begin
          errors++;
          $display("FAIL busy_idle got busy=%b required 0", bus.busy_o);
        end
      end
      if (sb.size() > 0 && edge_cnt > sb[0].edge_no) begin
        checks++;
        errors++;
        $display("FAIL missed_done at edge %0d required done at edge %0d data %h",
                 edge_cnt, sb[0].edge_no, sb[0].data);
        void'(sb.pop_front());
      end
      if (bus.done_o === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got data=%h required no done", bus.data_o);
        end else begin
          e = sb.pop_front();
          if (bus.data_o !== e.data || bus.zero_o !== e.zero || edge_cnt != e.edge_no) begin
            errors++;
            $display("FAIL result got data=%h zero=%b edge=%0d required data=%h zero=%b edge=%0d",
                     bus.data_o, bus.zero_o, edge_cnt, e.data, e.zero, e.edge_no);
          end
        end
        last_data = bus.data_o;
        last_zero = bus.zero_o;
      end else begin
        checks++;
        if (bus.done_o !== 1'b0 || bus.data_o !== last_data || bus.zero_o !== last_zero) begin
          errors++;
          $display("FAIL hold got done=%b data=%h zero=%b required done=0 data=%h zero=%b",
                   bus.done_o, bus.data_o, bus.zero_o, last_data, last_zero);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   g = 0;
    while (bus.busy_o !== 1'b0 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue_wait busy still %b after %0d cycles required 0", bus.busy_o, g);
    end
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = c;
    bus.data1_i   = a;
    bus.data2_i   = b;
    @(posedge clk);
    #1;
    e.data    = ref_alu(c, a, b);
    e.zero    = (e.data == '0);
    e.edge_no = edge_cnt + ((c == 3'b100) ? W : 0);
    sb.push_back(e);
    bus.start_i = 1'b0;
  endtask

  // Request presented without expecting any response (used while busy).
  task automatic poke(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = c;
    bus.data1_i   = a;
    bus.data2_i   = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain %0d results outstanding required 0", sb.size());
      sb.delete();
    end
  endtask

  logic [2:0] codes[8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b100, 3'b011, 3'b101, 3'b111};

  initial begin
    logic [2:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;

    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = '0;
    bus.data2_i   = '0;

    // Reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single-cycle ops back to back
    issue(3'b010, 32'd5, 32'd7);
    issue(3'b110, 32'd3, 32'd3);
    issue(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issue(3'b001, 32'h1000_0000, 32'h0000_0001);
    drain();

    // mul and wrap
    issue(3'b100, 32'd6, 32'd7);
    issue(3'b100, 32'hFFFF_FFFF, 32'd2);
    drain();

    // Start while busy: the add must be dropped
    issue(3'b100, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    poke(3'b010, 32'd1, 32'd1);
    drain();
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-mul
    issue(3'b100, 32'd9, 32'd9);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(3'b010, 32'd2, 32'd2);
    drain();

    // Unused code and zero product
    issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(3'b100, 32'd0, 32'h0000_1234);
    drain();

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      c = codes[$urandom_range(0, 7)];
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 15));
      issue(c, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Execute-stage ALU that consumes the 3-bit ALU control code from the ALU control decoder and the two 32-bit operands from the ID/EX register. add/sub/and/or complete in one cycle. mul runs as a 32-step shift-add iterative multiplier and holds `busy_o` so the hazard unit stalls the pipeline. Results are registered and qualified by a one-cycle `done_o` pulse toward the EX/MEM register.

## Interface
- `WIDTH`, 32, operand and result width in bits; also the mul iteration count.

- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  reset; synchronous, active-high.
- `start_i`  input  1  operation request; accepted only when `busy_o`=0.
- `ALUCtrl_i`  input  3  operation code: 010 add, 110 sub, 000 and, 001 or, 100 mul. All other codes are "unused".
- `data1_i`  input  WIDTH  operand A (rs1).
- `data2_i`  input  WIDTH  operand B (rs2 or immediate).
- `data_o`  output  WIDTH  registered result; holds its value until the next `done_o`.
- `zero_o`  output  1  registered flag, (`data_o`==0); updated together with `data_o`.
- `done_o`  output  1  one-cycle pulse: `data_o` and `zero_o` are newly valid this cycle.
- `busy_o`  output  1  mul in progress; the pipeline stalls while it is high.

## Operation
- States: IDLE, MUL.
- IDLE, `start_i`=1, code other than 100:
  - At that edge, `data_o` <= f(A,B). add is A+B; sub is A-B; and is A&B; or is A|B; unused codes give 0.
  - `zero_o` <= (result==0) and `done_o` <= 1. The state stays IDLE.
- IDLE, `start_i`=1, code 100:
  - At that edge, load mcand <= A, mplier <= B, acc <= 0, cnt <= 0.
  - State <= MUL, `done_o` <= 0.
- MUL, each edge:
  - If mplier[0], acc <= acc + mcand (mod 2^WIDTH).
  - mcand <= mcand<<1, mplier <= mplier>>1, cnt <= cnt+1.
- MUL, edge where cnt==WIDTH-1:
  - `data_o` <= final acc, including this step's add. This is the low WIDTH bits of A*B; the product is unsigned and also correct mod 2^WIDTH for two's-complement operands.
  - `zero_o` updated, `done_o` <= 1, state <= IDLE.
- No early termination. mul always takes exactly WIDTH iterations.
- `start_i` while in MUL: ignored. The operands and code are not latched, and no `done_o` results from them.
- `busy_o` = (state==MUL), driven from registered state.
- `done_o` is 0 on every edge that does not complete an operation. `done_o` never stays high two cycles for the same operation.
- All arithmetic wraps modulo 2^WIDTH. No overflow or carry outputs.

## Timing
- Reset (`rst_i`=1 at an edge):
  - Outputs: `data_o`=0, `zero_o`=0, `done_o`=0, `busy_o`=0.
  - Internals: state IDLE; cnt, acc, mcand and mplier are all 0.
  - Reset takes priority over every other action.
- Single-cycle ops:
  - Request sampled at edge E; `done_o`/`data_o` are valid in the cycle after E. Latency is 1.
  - Back-to-back requests on consecutive edges give a `done_o` in every cycle.
- mul:
  - Accepted at edge E0. `busy_o`=1 from after E0 through the cycle ending at edge E0+WIDTH.
  - Result is written at edge E0+WIDTH. `done_o`=1 and `busy_o`=0 in the following cycle. Latency is WIDTH+1 edges (33 at default).
  - A new `start_i` is accepted at edge E0+WIDTH+1 at the earliest.
- Reset during MUL: the operation is abandoned with no `done_o`, and all outputs return to reset values at that edge.
- `start_i`=0 in IDLE: `data_o` and `zero_o` hold; `done_o`=0.

## Test plan
- Reset then idle:
  - Stimulus: assert `rst_i` 2 cycles, then `start_i`=0 for 5 cycles.
  - Required: `data_o`=0, `zero_o`=0, `done_o`=0 and `busy_o`=0 throughout.
- Single-cycle ops on consecutive edges:
  - Stimulus: add 5+7, sub 3-3, and 0xF0F0_F0F0&0x0FF0_0FF0, or 0x1000_0000|0x1.
  - Required: `done_o`=1 each following cycle. `data_o` = 0x0000_000C, 0, 0x00F0_00F0, 0x1000_0001. `zero_o`=1 only for sub.
- mul 6*7 and wrap:
  - Stimulus: mul 6*7, then mul 0xFFFF_FFFF*2.
  - Required: `busy_o` high for exactly 32 cycles each. `done_o` arrives 33 edges after accept, with `data_o`=42 and then 0xFFFF_FFFE.
- Start while busy:
  - Stimulus: during a mul 3*4, pulse `start_i` with add 1+1 at cycle 10.
  - Required: exactly one `done_o`, with `data_o`=12. The add is never executed.
- Reset mid-mul:
  - Stimulus: start mul 9*9, assert `rst_i` at cycle 15.
  - Required: outputs go to reset values at that edge, and no `done_o` follows. A later add 2+2 returns 4 after 1 cycle.
- Unused code and zero product:
  - Stimulus: code 011 with any operands; mul 0*0x1234.
  - Required: `data_o`=0, `zero_o`=1, `done_o` after 1 cycle and after 33 edges respectively.
